// File: rtl/alu_issue_pkg.sv
// Shared encodings for the ALU issue controller: instruction ops, ALU opControl
// codes, FSM states and architectural flag bit positions.
package alu_issue_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_AND  = 2'b01;
  localparam logic [1:0] OP_OR   = 2'b10;
  localparam logic [1:0] OP_ADDC = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  localparam int FLAG_C = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, EXEC, WB} state_t;

  function automatic logic is_add(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_ADDC);
  endfunction

  // ADDC has no ALU opcode of its own; it is an ADD with carry-in.
  function automatic logic [1:0] alu_op_of(input logic [1:0] op);
    case (op)
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_flag_update.sv
// Next-state {C, Z, N} from the ALU outputs; logic ops keep the old carry.
module alu_flag_update
  import alu_issue_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [1:0]   op_i,
  input  logic [2:0]   czn_i,
  input  logic [W-1:0] result_i,
  input  logic [2:0]   flags_i,
  output logic [2:0]   flags_o
);

  // N comes from the result MSB, so the ALU's own n bit is deliberately dropped.
  logic unused_n;
  assign unused_n = czn_i[FLAG_N];

  always_comb begin
    flags_o         = flags_i;
    flags_o[FLAG_Z] = czn_i[FLAG_Z];
    flags_o[FLAG_N] = result_i[W-1];
    if (is_add(op_i)) flags_o[FLAG_C] = czn_i[FLAG_C];
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Multi-cycle issue FSM: fetch two operands over one read port, run the ALU,
// write back and pulse done. ALU_ISSUE_SAME_SRC_EN skips RD_B when rs == rt.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int W  = 8,
  parameter int RA = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [1:0]    instr_op,
  input  logic [RA-1:0] instr_rd,
  input  logic [RA-1:0] instr_rs,
  input  logic [RA-1:0] instr_rt,
  output logic [RA-1:0] rf_raddr,
  input  logic [W-1:0]  rf_rdata,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [1:0]    alu_op,
  output logic          alu_cin,
  input  logic [W-1:0]  alu_result,
  input  logic [2:0]    alu_czn,
  output logic          rf_we,
  output logic [RA-1:0] rf_waddr,
  output logic [W-1:0]  rf_wdata,
  output logic [2:0]    flags,
  output logic          busy,
  output logic          done
);

  state_t        state_q;
  logic [1:0]    op_q;
  logic [RA-1:0] rd_q, rt_q, raddr_q, waddr_q;
  logic [W-1:0]  alu_a_q, alu_b_q, wdata_q;
  logic [1:0]    alu_op_q;
  logic          alu_cin_q, we_q;
  logic [2:0]    flags_q, flags_d;
`ifdef ALU_ISSUE_SAME_SRC_EN
  logic          same_q;
`endif

  alu_flag_update #(.W(W)) u_flag (
    .op_i    (op_q),
    .czn_i   (alu_czn),
    .result_i(alu_result),
    .flags_i (flags_q),
    .flags_o (flags_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      rd_q      <= '0;
      rt_q      <= '0;
      raddr_q   <= '0;
      waddr_q   <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      wdata_q   <= '0;
      alu_op_q  <= ALU_ADD;
      alu_cin_q <= 1'b0;
      we_q      <= 1'b0;
      flags_q   <= 3'b000;
`ifdef ALU_ISSUE_SAME_SRC_EN
      same_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (instr_valid) begin
          op_q    <= instr_op;
          rd_q    <= instr_rd;
          rt_q    <= instr_rt;
          raddr_q <= instr_rs;
`ifdef ALU_ISSUE_SAME_SRC_EN
          same_q  <= (instr_rs == instr_rt);
`endif
          state_q <= RD_A;
        end
        RD_A: begin
          alu_a_q <= rf_rdata;
`ifdef ALU_ISSUE_SAME_SRC_EN
          if (same_q) begin
            // One read serves both operands; the read address stays on rs.
            alu_b_q   <= rf_rdata;
            alu_op_q  <= alu_op_of(op_q);
            alu_cin_q <= (op_q == OP_ADDC) && flags_q[FLAG_C];
            state_q   <= EXEC;
          end else begin
            raddr_q <= rt_q;
            state_q <= RD_B;
          end
`else
          raddr_q <= rt_q;
          state_q <= RD_B;
`endif
        end
        RD_B: begin
          alu_b_q   <= rf_rdata;
          alu_op_q  <= alu_op_of(op_q);
          alu_cin_q <= (op_q == OP_ADDC) && flags_q[FLAG_C];
          state_q   <= EXEC;
        end
        EXEC: begin
          wdata_q <= alu_result;
          waddr_q <= rd_q;
          flags_q <= flags_d;
          we_q    <= 1'b1;
          state_q <= WB;
        end
        WB: begin
          we_q    <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign rf_raddr    = raddr_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign alu_cin     = alu_cin_q;
  assign rf_we       = we_q;
  assign done        = we_q;
  assign rf_waddr    = waddr_q;
  assign rf_wdata    = wdata_q;
  assign flags       = flags_q;

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Multi-cycle initiator for the 8-bit ALU (ops ADD=00, AND=01, OR=10; inputs a, b, c; outputs result, czn).
- Accepts one instruction per transaction over a valid/ready handshake.
- Reads both source operands through the single register-file read port, one per cycle.
- Drives the ALU, captures the result and flags, writes back, then pulses done.
- Sits between the instruction decoder and the ALU/register file.

Parameters:
W, 8, datapath width; must match the ALU.
RA, 3, register-file address width.

Ports:
clk  in  1  single clock; all state changes on rising edge.
rst  in  1  reset, asynchronous, active-high.
instr_valid  in  1  instruction offered.
instr_ready  out  1  high only in IDLE.
instr_op  in  2  00 ADD, 01 AND, 10 OR, 11 ADDC (add with carry).
instr_rd  in  RA  destination register.
instr_rs  in  RA  source A.
instr_rt  in  RA  source B.
rf_raddr  out  RA  register-file read address.
rf_rdata  in  W  combinational read data, valid in the same cycle.
alu_a  out  W  ALU operand a (registered).
alu_b  out  W  ALU operand b (registered).
alu_op  out  2  ALU opControl (registered).
alu_cin  out  1  ALU carry-in (registered).
alu_result  in  W  ALU result.
alu_czn  in  3  ALU {c, z, n}.
rf_we  out  1  write enable; single-cycle pulse.
rf_waddr  out  RA  write address.
rf_wdata  out  W  write data.
flags  out  3  architectural {C, Z, N} register.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse, coincident with rf_we.

Behaviour:
- States and transitions:
  - IDLE -> RD_A on instr_valid && instr_ready; latches op, rd, rs, rt.
  - RD_A -> RD_B: rf_raddr = rs; opa <= rf_rdata.
  - RD_B -> EXEC: rf_raddr = rt; opb <= rf_rdata.
  - EXEC -> WB: alu_a/alu_b/alu_op/alu_cin are stable for the whole cycle; alu_result and alu_czn are sampled at the closing edge.
  - WB -> IDLE: rf_we = 1, rf_waddr = rd, rf_wdata = captured result, done = 1.
- Latency: handshake edge at cycle 0; done and rf_we are high in cycle 4. Throughput is one instruction per 5 cycles.
- rf_raddr in IDLE, EXEC and WB: holds its last value. It is never a write hazard, because the port is read-only.
- Op mapping:
  - ADD -> alu_op 00, cin 0.
  - ADDC -> alu_op 00, cin = flags.C at EXEC entry.
  - AND -> alu_op 01, cin 0.
  - OR -> alu_op 10, cin 0.
- Flag update (at EXEC exit):
  - Z = alu_czn[1].
  - N = alu_result[7]; the ALU's n bit is ignored.
  - C = alu_czn[2] for ADD/ADDC only; AND/OR preserve C.
- Width: W-bit wrap-around; the carry-out appears only in C.
- instr_valid while busy: ignored; instr_ready stays low. There is no queueing.
- rd equal to rs or rt: legal; operands are latched before write-back.
- Reset values:
  - State IDLE; flags 3'b000.
  - alu_a, alu_b, alu_op, alu_cin, rf_raddr, rf_waddr, rf_wdata: 0.
  - rf_we, done, busy: 0; instr_ready: 1 once reset deasserts.
- Reset mid-operation: aborts immediately. No write-back occurs and no done pulse is produced; flags are cleared.

Optional Feature:
ALU_ISSUE_SAME_SRC_EN
- Defined: when rs == rt, RD_A loads both opa and opb and the FSM goes directly to EXEC. done then falls in cycle 3.
- Undefined: RD_B is always visited; latency is fixed at 4.

Decomposition:
- Package alu_issue_pkg holds:
  - op encodings: OP_ADD, OP_AND, OP_OR, OP_ADDC;
  - the ALU opControl codes;
  - the state enum: IDLE, RD_A, RD_B, EXEC, WB;
  - flag bit indices: FLAG_C = 2, FLAG_Z = 1, FLAG_N = 0.
- One sub-module, alu_flag_update: a purely combinational next-flags function of (op, alu_czn, alu_result, current flags).

Test Plan:
- Basic ADD: r1 = 8'h05, r2 = 8'h03, ADD rd = 3 -> rf_wdata 8'h08 at cycle 4; flags 3'b000; done exactly one cycle.
- ADD carry: r1 = 8'hFF, r2 = 8'h01 -> result 8'h00, flags C = 1, Z = 1, N = 0. A following ADDC of 8'h10 + 8'h00 -> 8'h11, C = 0.
- Logic preserves C: set C = 1 via overflow, then AND 8'hF0 & 8'h80 -> 8'h80, flags {1, 0, 1}.
- Busy handshake: hold instr_valid high for 10 cycles -> exactly two acceptances, 5 cycles apart; instr_ready low in cycles 1–4.
- Reset in EXEC: assert rst mid-EXEC -> no rf_we, no done, flags 0, instr_ready high after release.
- SAME_SRC: rs = rt = 4 holding 8'h40, ADD -> 8'h80, N = 1. With the macro defined, done falls in cycle 3 and rf_raddr never presents rt in a separate cycle; without it, done falls in cycle 4.
